// File: rtl/ula_pkg.sv
// Shared ALU constants: data/op widths and the op-code map understood by the ula.
package ula_pkg;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] ADD     = 4'b0000;
    localparam logic [OP_W-1:0] SUB     = 4'b0001;
    localparam logic [OP_W-1:0] AND     = 4'b0010;
    localparam logic [OP_W-1:0] OR      = 4'b0011;
    localparam logic [OP_W-1:0] XOR     = 4'b0100;
    localparam logic [OP_W-1:0] NOR     = 4'b0101;
    localparam logic [OP_W-1:0] SLT     = 4'b0110;
    localparam logic [OP_W-1:0] SLTU    = 4'b0111;
    localparam logic [OP_W-1:0] SLL     = 4'b1000;
    localparam logic [OP_W-1:0] SRL     = 4'b1001;
    localparam logic [OP_W-1:0] SRA     = 4'b1010;
    localparam logic [OP_W-1:0] OP_LAST = 4'b1010;
endpackage

// File: rtl/ula_arbiter_if.sv
// Request/response bundle between the issue logic (master) and the ula arbiter (slave).
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface ula_arbiter_if #(parameter int NREQ = 2) ();
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]                     req_valid;
    logic [NREQ-1:0]                     req_ready;
    logic [NREQ*ula_pkg::DATA_W-1:0]     req_in1;
    logic [NREQ*ula_pkg::DATA_W-1:0]     req_in2;
    logic [NREQ*ula_pkg::OP_W-1:0]       req_op;
    logic                                rsp_valid;
    logic                                rsp_ready;
    logic [IDW-1:0]                      rsp_id;
    logic [ula_pkg::DATA_W-1:0]          rsp_result;
    logic                                rsp_zero;
    logic                                rsp_illegal;
    logic [15:0]                         ops_count;
    logic [IDW-1:0]                      dbg_ptr;

    modport master (
        output req_valid, req_in1, req_in2, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal,
               ops_count, dbg_ptr
    );
    modport slave (
        input  req_valid, req_in1, req_in2, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal,
               ops_count, dbg_ptr
    );
endinterface

// File: rtl/rr_arb.sv
// Round-robin pick: first set request searching ptr, ptr+1, ... wrapping modulo NREQ.
module rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  win_o,
    output logic            any_o
);
    logic found;
    int   idx;

    always_comb begin
        gnt_o = '0;
        win_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                win_o      = IDW'(idx);
            end
        end
        any_o = found;
    end
endmodule

// File: rtl/ula.sv
// 32-bit ALU. For shifts in1[4:0] is the distance and in2 the shifted value; unknown ops give 0.
module ula
    import ula_pkg::*;
(
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);
    always_comb begin
        result = '0;
        case (op)
            ADD:     result = in1 + in2;
            SUB:     result = in1 - in2;
            AND:     result = in1 & in2;
            OR:      result = in1 | in2;
            XOR:     result = in1 ^ in2;
            NOR:     result = ~(in1 | in2);
            SLT:     result = {{(DATA_W-1){1'b0}}, ($signed(in1) < $signed(in2))};
            SLTU:    result = {{(DATA_W-1){1'b0}}, (in1 < in2)};
            SLL:     result = in2 << in1[4:0];
            SRL:     result = in2 >> in1[4:0];
            SRA:     result = $unsigned($signed(in2) >>> in1[4:0]);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/ula_arbiter.sv
// Shares one ula between NREQ requesters: round-robin grant, one-entry registered response
// tagged with the winner's ID, and a wrapping count of delivered responses.
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic          clk,
    input  logic          rst,
    ula_arbiter_if.slave  bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]    ptr_q, ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_illegal_q, rsp_illegal_d;
    logic [15:0]       ops_count_q, ops_count_d;

    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    win;
    logic              any_req;
    logic              can_acc;
    logic              accept;
    logic [DATA_W-1:0] alu_in1, alu_in2, alu_result;
    logic [OP_W-1:0]   alu_op;
    logic              alu_zero;

    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_rr_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .win_o (win),
        .any_o (any_req)
    );

    // The output register can take a new result when empty or when it is being drained now.
    assign can_acc       = !rsp_valid_q || bus.rsp_ready;
    assign accept        = can_acc && any_req && !rst;
    assign bus.req_ready = accept ? gnt : '0;

    assign alu_in1 = bus.req_in1[DATA_W*int'(win) +: DATA_W];
    assign alu_in2 = bus.req_in2[DATA_W*int'(win) +: DATA_W];
    assign alu_op  = bus.req_op[OP_W*int'(win) +: OP_W];

    ula u_ula (
        .in1    (alu_in1),
        .in2    (alu_in2),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_comb begin
        ptr_d         = ptr_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_illegal_d = rsp_illegal_q;
        ops_count_d   = ops_count_q;
        if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
            ops_count_d = ops_count_q + 16'd1;
        end
        if (accept) begin
            rsp_valid_d   = 1'b1;
            rsp_id_d      = win;
            rsp_result_d  = alu_result;
            rsp_zero_d    = alu_zero;
            rsp_illegal_d = (alu_op > OP_LAST);
            ptr_d         = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
            ops_count_q   <= '0;
        end else begin
            ptr_q         <= ptr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_illegal_q <= rsp_illegal_d;
            ops_count_q   <= ops_count_d;
        end
    end

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_illegal = rsp_illegal_q;
    assign bus.ops_count   = ops_count_q;
    assign bus.dbg_ptr     = ptr_q;
endmodule
